seq_multiplier: RTL
===================

// Module: seq_multiplier
// PURPOSE
//  Parametrised sequential NxN multiplier; successor to the 2x2 dataflow multiplier.
//  Radix-2 shift-add over WIDTH cycles; start/busy/done handshake; optional signed mode.
//  Used wherever a wide product is needed without a full combinational array.
// PARAMETERS
//  WIDTH      4  operand width in bits (>=2); product is 2*WIDTH bits
//  SIGNED_EN  1  1: signed_mode honoured (two's complement); 0: signed_mode ignored, always unsigned
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        asynchronous, active-high reset
//  start        in   1        request; sampled only when not busy
//  signed_mode  in   1        1: a,b,c two's complement (sampled with start)
//  a            in   WIDTH    multiplicand (sampled with start)
//  b            in   WIDTH    multiplier (sampled with start)
//  busy         out  1        operation in progress
//  done         out  1        one-cycle pulse, c valid
//  c            out  2*WIDTH  product, held until next accepted start
// BEHAVIOUR
//  - Reset (asserts async, releases at clk edge): state=IDLE, busy=0, done=0, c=0, internals=0.
//  - States: IDLE -> RUN on start; RUN -> DONE after WIDTH iterations; DONE -> RUN if start
//    else IDLE. DONE lasts exactly one cycle.
//  - Accept: start high at edge E0 while state in {IDLE, DONE}. a, b, signed_mode latched at E0.
//    In signed mode, operands latched as magnitudes; neg flag = sign(a) XOR sign(b).
//  - |-2^(WIDTH-1)| = 2^(WIDTH-1) fits in WIDTH unsigned bits; no overflow special case.
//  - RUN: each edge tests LSB of multiplier reg; if 1, acc[2W-1:W] += multiplicand (W+1-bit sum).
//    acc then shifts right 1 (carry in MSB). Iteration counter: $clog2(WIDTH)+1 bits.
//  - Edge E0+WIDTH: c <= neg ? -acc_final : acc_final (2*WIDTH-bit two's complement), state=DONE.
//  - Timing: busy=1 in cycles after E0 .. E0+WIDTH-1; busy=0 and done=1 in cycle after E0+WIDTH.
//    Latency: WIDTH edges start-accept to done; throughput: one product per WIDTH+1 cycles.
//  - start while busy: ignored, no effect on operands or count. start in DONE cycle: accepted
//    (back-to-back); done still pulses that cycle, busy=1 the next.
//  - c changes only at completion edge; not at accept. c holds the prior product during RUN.
//  - Zero operand: full WIDTH iterations still run (no early exit); latency fixed.
//  - rst mid-RUN: immediate abort; c=0, done never pulses for the aborted op.
//  - Unsigned: c = a*b exactly. Signed: c = $signed(a)*$signed(b) exactly. No saturation.
// STRUCTURE
//  - Shared header mult_defs.vh: state encoding localparams (ST_IDLE=2'd0, ST_RUN=2'd1,
//    ST_DONE=2'd2). Shared by later multiplier/divider variants.
//  - One sub-module natural: mult_abs #(WIDTH): combinational sign strip of one operand,
//    outputs magnitude[WIDTH-1:0] and sign bit; instantiated for a and b.
//  - Datapath (acc, multiplicand, counter, neg) and FSM in seq_multiplier; no other hierarchy.
// TESTING (WIDTH=4 unless noted; compare every done against a*b reference model)
//  - Unsigned 2'b11-class: a=3,b=3,signed_mode=0 -> done 4 edges after accept, c=8'd9.
//  - Unsigned max: a=15,b=15 -> c=8'd225; a=0,b=13 -> c=0, still 4-cycle latency.
//  - Signed: a=-8,b=-8 -> c=8'd64; a=-3,b=5 -> c=8'hF1; a=7,b=-1 -> c=8'hF9.
//  - SIGNED_EN=0: a=4'hD,b=5,signed_mode=1 -> c=8'd65 (unsigned).
//  - Handshake: start held high continuously -> start mid-RUN ignored; back-to-back accepted
//    on DONE cycles, one done pulse per 5 cycles; busy and done never both high.
//  - Reset: rst asserted mid-RUN (2 edges after accept) -> busy=0, c=0 at once, no done;
//    next start after release completes normally.
//  - Sweep: WIDTH=8, all 65536 signed and unsigned operand pairs vs reference model.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier family:
// FSM state encoding and a sizing helper for the iteration counter.
package seq_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Iteration counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/busy/done handshake and operand/product bus of the sequential multiplier.
interface seq_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   c;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, c
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, c
    );
endinterface

// File: rtl/seq_multiplier_abs.sv
// Combinational sign strip of one operand: magnitude plus sign bit.
// The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
module seq_multiplier_abs #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_signed,
    output logic [WIDTH-1:0] o_mag,
    output logic             o_sign
);
    assign o_sign = i_signed & i_value[WIDTH-1];
    assign o_mag  = o_sign ? -i_value : i_value;
endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add NxN multiplier: WIDTH iterations per product, optional
// signed mode via magnitude multiply and final conditional negation.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    seq_multiplier_if.slave     bus
);
    localparam int              CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_c;
    logic [WIDTH-1:0]     r_mcand;
    logic [CW-1:0]        r_cnt;
    logic                 r_neg;

    logic                 w_signed;
    logic                 w_sign_a;
    logic                 w_sign_b;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign w_signed = SIGNED_EN & bus.signed_mode;

    seq_multiplier_abs #(.WIDTH(WIDTH)) u_abs_a (
        .i_value  (bus.a),
        .i_signed (w_signed),
        .o_mag    (w_mag_a),
        .o_sign   (w_sign_a)
    );

    seq_multiplier_abs #(.WIDTH(WIDTH)) u_abs_b (
        .i_value  (bus.b),
        .i_signed (w_signed),
        .o_mag    (w_mag_b),
        .o_sign   (w_sign_b)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == LAST) begin
                    w_last       = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Multiplier lives in the low half of acc and is consumed as it shifts out.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: the whole datapath is reset, so an aborted operation leaves nothing behind in c.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_c     <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
            r_mcand <= w_mag_a;
            r_neg   <= w_sign_a ^ w_sign_b;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) r_c <= r_neg ? -w_acc_next : w_acc_next;
        end
    end

    assign bus.busy = (r_state == ST_RUN);
    assign bus.done = (r_state == ST_DONE);
    assign bus.c    = r_c;

endmodule
